mem_arbiter: RTL

- Owns the single port of the 16x4 program/data register memory.
- Shares that port between the CPU core (fetch/load/store) and a host programming port fed from the chip I/O pins.
- While the host programs or reads back memory, the CPU is stalled. The host uses an auto-incrementing address pointer with a valid/ready handshake.
- Sits between the CPU core, the pin-level loader and the memory in the top level.

---
 rtl/mem_arbiter_pkg.sv | 27 ++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the program/data memory arbiter.
// The opcode constants give names to the values the bench preloads into the memory.
package mem_arbiter_pkg;

    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DATA_WIDTH_DEF = 4;
    localparam int DEPTH_DEF      = 16;

    typedef enum logic [1:0] {
        CPU_RUN   = 2'd0,
        HOST_IDLE = 2'd1,
        HOST_RD   = 2'd2,
        RELEASE   = 2'd3
    } arb_state_e;

    // Instruction opcodes of the 4-bit core
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between the CPU core and the host programming port.
// While the host owns memory the CPU is stalled; the host walks memory with an auto-incrementing pointer.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic                  cpu_gnt_o,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_stall_o,
    input  logic                  host_prog_i,
    input  logic                  host_valid_i,
    input  logic                  host_we_i,
    input  logic [DATA_WIDTH-1:0] host_data_i,
    input  logic                  host_ptr_clr_i,
    output logic                  host_ready_o,
    output logic [DATA_WIDTH-1:0] host_rdata_o,
    output logic                  host_rvalid_o,
    output logic [ADDR_WIDTH-1:0] host_ptr_o,
    output logic                  prog_done_o,
    output logic                  mem_write_en_o,
    output logic                  mem_read_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    input  logic [DATA_WIDTH-1:0] mem_data_i
);

    arb_state_e            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] ptr_reg, ptr_next;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  rvalid_reg;
    logic                  done_reg;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic [ADDR_WIDTH-1:0] eff_addr_inc;
    logic                  host_rd_xfer;

    // A pointer clear in the same cycle as a transfer redirects that transfer to address 0
    assign eff_addr     = host_ptr_clr_i ? '0 : ptr_reg;
    assign eff_addr_inc = (eff_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : eff_addr + 1'b1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg  <= CPU_RUN;
            ptr_reg    <= '0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            rvalid_reg <= (state_next == HOST_RD);
            done_reg   <= (state_reg == RELEASE);
            if (host_rd_xfer) begin
                rdata_reg <= mem_data_i;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = eff_addr;
        host_rd_xfer   = 1'b0;
        cpu_gnt_o      = 1'b0;
        host_ready_o   = 1'b0;
        mem_write_en_o = 1'b0;
        mem_read_en_o  = 1'b0;
        mem_addr_o     = '0;
        mem_data_o     = '0;
        case (state_reg)
            CPU_RUN: begin
                cpu_gnt_o      = cpu_req_i;
                mem_write_en_o = cpu_req_i & cpu_we_i;
                mem_read_en_o  = cpu_req_i & ~cpu_we_i;
                mem_addr_o     = cpu_req_i ? cpu_addr_i : '0;
                mem_data_o     = (cpu_req_i & cpu_we_i) ? cpu_wdata_i : '0;
                if (host_prog_i) begin
                    state_next = HOST_IDLE;
                end
            end
            HOST_IDLE: begin
                host_ready_o = 1'b1;
                if (host_valid_i) begin
                    mem_write_en_o = host_we_i;
                    mem_read_en_o  = ~host_we_i;
                    mem_addr_o     = eff_addr;
                    mem_data_o     = host_we_i ? host_data_i : '0;
                    ptr_next       = eff_addr_inc;
                    host_rd_xfer   = ~host_we_i;
                    if (!host_we_i) begin
                        state_next = HOST_RD;
                    end else if (!host_prog_i) begin
                        state_next = RELEASE;
                    end
                end else if (!host_prog_i) begin
                    state_next = RELEASE;
                end
            end
            HOST_RD: begin
                state_next = host_prog_i ? HOST_IDLE : RELEASE;
            end
            RELEASE: begin
                state_next = CPU_RUN;
            end
        endcase
    end

    assign cpu_stall_o   = (state_reg != CPU_RUN);
    assign cpu_rdata_o   = cpu_gnt_o ? mem_data_i : '0;
    assign host_rdata_o  = rdata_reg;
    assign host_rvalid_o = rvalid_reg;
    assign host_ptr_o    = ptr_reg;
    assign prog_done_o   = done_reg;

endmodule
